// File: rtl/reg_write_back_pkg.sv
// rtl/reg_write_back_pkg.sv - instruction type, result source and FSM state codes for write-back
package reg_write_back_pkg;

    localparam logic [2:0] TYPER = 3'd0;
    localparam logic [2:0] TYPEI = 3'd1;
    localparam logic [2:0] TYPES = 3'd2;
    localparam logic [2:0] TYPEB = 3'd3;
    localparam logic [2:0] TYPEU = 3'd4;
    localparam logic [2:0] TYPEJ = 3'd5;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_IMM = 2'd3;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_t;

    // Stores and branches retire without touching the register file.
    function automatic logic type_writes(input logic [2:0] instr_type);
        return (instr_type == TYPER) || (instr_type == TYPEI) ||
               (instr_type == TYPEU) || (instr_type == TYPEJ);
    endfunction

endpackage

// File: rtl/reg_write_back_if.sv
// rtl/reg_write_back_if.sv - write-back request, load return and decode read-port bundle
interface reg_write_back_if #(
    parameter int XLEN = 32
);
    logic            wb_valid_i;
    logic [2:0]      instr_type_i;
    logic [4:0]      rd_i;
    logic [1:0]      wb_sel_i;
    logic [XLEN-1:0] alu_result_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] imm_i;
    logic [4:0]      rs1_i;
    logic [4:0]      rs2_i;
    logic            valid_src1_i;
    logic            valid_src2_i;
    logic [XLEN-1:0] val1_o;
    logic [XLEN-1:0] val2_o;
    logic            stall_o;
    logic            load_err_o;
    logic [31:0]     retired_cnt_o;

    modport master (
        output wb_valid_i, instr_type_i, rd_i, wb_sel_i, alu_result_i,
               mem_rdata_i, mem_rvalid_i, pc_i, imm_i,
               rs1_i, rs2_i, valid_src1_i, valid_src2_i,
        input  val1_o, val2_o, stall_o, load_err_o, retired_cnt_o
    );

    modport slave (
        input  wb_valid_i, instr_type_i, rd_i, wb_sel_i, alu_result_i,
               mem_rdata_i, mem_rvalid_i, pc_i, imm_i,
               rs1_i, rs2_i, valid_src1_i, valid_src2_i,
        output val1_o, val2_o, stall_o, load_err_o, retired_cnt_o
    );

endinterface

// File: rtl/reg_write_back_regfile_storage.sv
// rtl/reg_write_back_regfile_storage.sv - architectural register array, one write port, two async read ports
module regfile_storage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 reads as zero regardless of what the array holds.
    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/reg_write_back.sv
// rtl/reg_write_back.sv - write-back FSM, source mux, load timeout, retire counter; WB_BYPASS_EN enables same-cycle read forwarding
module reg_write_back
    import reg_write_back_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    reg_write_back_if.slave  bus
);

    localparam int CW = $clog2(LOAD_TIMEOUT + 1);

    wb_state_t       state;
    logic [CW-1:0]   wait_cnt;
    logic [4:0]      rd_q;
    logic            load_err;
    logic [31:0]     retired_cnt;

    logic [XLEN-1:0] src_data;
    logic [4:0]      wb_rd;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            retire;
    logic            enter_wait;
    logic            timeout;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;

    always_comb begin
        case (bus.wb_sel_i)
            WB_SEL_ALU: src_data = bus.alu_result_i;
            WB_SEL_MEM: src_data = bus.mem_rdata_i;
            WB_SEL_PC4: src_data = bus.pc_i + XLEN'(4);
            default:    src_data = bus.imm_i;
        endcase
    end

    // Non-writing types are folded onto x0 so the rest of the path needs no type check.
    assign wb_rd = type_writes(bus.instr_type_i) ? bus.rd_i : 5'd0;

    always_comb begin
        wr_en      = 1'b0;
        wr_addr    = wb_rd;
        wr_data    = src_data;
        retire     = 1'b0;
        enter_wait = 1'b0;
        timeout    = 1'b0;
        if (state == WB_IDLE) begin
            if (bus.wb_valid_i) begin
                if ((bus.wb_sel_i == WB_SEL_MEM) && !bus.mem_rvalid_i) begin
                    enter_wait = 1'b1;
                end else begin
                    retire = 1'b1;
                    wr_en  = (wb_rd != 5'd0);
                end
            end
        end else begin
            wr_addr = rd_q;
            wr_data = bus.mem_rdata_i;
            if (bus.mem_rvalid_i) begin
                retire = 1'b1;
                wr_en  = (rd_q != 5'd0);
            end else if (wait_cnt == CW'(LOAD_TIMEOUT - 1)) begin
                timeout = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= WB_IDLE;
            wait_cnt    <= '0;
            rd_q        <= '0;
            load_err    <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (retire) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            case (state)
                WB_IDLE: begin
                    if (enter_wait) begin
                        state    <= WB_WAIT_MEM;
                        wait_cnt <= '0;
                        rd_q     <= wb_rd;
                    end
                end
                WB_WAIT_MEM: begin
                    if (retire) begin
                        state <= WB_IDLE;
                    end else if (timeout) begin
                        load_err <= 1'b1;
                        state    <= WB_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    regfile_storage #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_storage (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we      (wr_en),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr1  (bus.rs1_i),
        .raddr2  (bus.rs2_i),
        .rdata1  (rdata1),
        .rdata2  (rdata2)
    );

    always_comb begin
        bus.val1_o = '0;
        bus.val2_o = '0;
        if (bus.valid_src1_i && (bus.rs1_i != 5'd0)) begin
            bus.val1_o = rdata1;
`ifdef WB_BYPASS_EN
            if (wr_en && (wr_addr == bus.rs1_i)) bus.val1_o = wr_data;
`endif
        end
        if (bus.valid_src2_i && (bus.rs2_i != 5'd0)) begin
            bus.val2_o = rdata2;
`ifdef WB_BYPASS_EN
            if (wr_en && (wr_addr == bus.rs2_i)) bus.val2_o = wr_data;
`endif
        end
    end

    assign bus.stall_o       = (state == WB_WAIT_MEM) || enter_wait;
    assign bus.load_err_o    = load_err;
    assign bus.retired_cnt_o = retired_cnt;

endmodule

// File: tb/tb_reg_write_back.sv
// tb/tb_reg_write_back.sv - scoreboard bench for reg_write_back with LOAD_TIMEOUT=4
module tb_reg_write_back;
    import reg_write_back_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_write_back_if #(.XLEN(32)) bus ();

    reg_write_back #(
        .XLEN         (32),
        .NREGS        (32),
        .LOAD_TIMEOUT (4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        string       tag;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;
    int          exp_retired = 0;
    int          stall_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wb_valid_i   = 1'b0;
        bus.instr_type_i = TYPER;
        bus.rd_i         = '0;
        bus.wb_sel_i     = WB_SEL_ALU;
        bus.alu_result_i = '0;
        bus.mem_rdata_i  = '0;
        bus.mem_rvalid_i = 1'b0;
        bus.pc_i         = '0;
        bus.imm_i        = '0;
        bus.rs1_i        = '0;
        bus.rs2_i        = '0;
        bus.valid_src1_i = 1'b0;
        bus.valid_src2_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_retired = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_reg(input string tag, input logic [4:0] addr);
        sbq.push_back('{tag, addr, model[addr]});
    endtask

    task automatic drain_reads();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            bus.rs1_i = e.addr;
            bus.rs2_i = e.addr;
            bus.valid_src1_i = 1'b1;
            bus.valid_src2_i = 1'b1;
            #1;
            check({e.tag, "_p1"}, bus.val1_o, e.data);
            check({e.tag, "_p2"}, bus.val2_o, e.data);
        end
        bus.valid_src1_i = 1'b0;
        bus.valid_src2_i = 1'b0;
    endtask

    task automatic wb_op(input logic [2:0] t, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm);
        logic [31:0] v;
        bus.wb_valid_i   = 1'b1;
        bus.instr_type_i = t;
        bus.rd_i         = rd;
        bus.wb_sel_i     = sel;
        bus.alu_result_i = alu;
        bus.pc_i         = pc;
        bus.imm_i        = imm;
        case (sel)
            WB_SEL_ALU: v = alu;
            WB_SEL_PC4: v = pc + 32'd4;
            WB_SEL_IMM: v = imm;
            default:    v = bus.mem_rdata_i;
        endcase
        if ((t == TYPER || t == TYPEI || t == TYPEU || t == TYPEJ) && rd != 5'd0) model[rd] = v;
        exp_retired++;
        tick();
        bus.wb_valid_i = 1'b0;
    endtask

    // Load lasting n cycles from the IDLE request; rvalid pulses on cycle rv_at (-1 = never).
    task automatic load_seq(input logic [4:0] rd, input logic [31:0] data, input int rv_at, input int n);
        bus.wb_valid_i   = 1'b1;
        bus.instr_type_i = TYPEI;
        bus.rd_i         = rd;
        bus.wb_sel_i     = WB_SEL_MEM;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0BAD_0BAD;
        stall_cycles     = 0;
        for (int k = 0; k < n; k++) begin
            if (k == rv_at) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = data;
            end
            @(negedge clk);
            if (bus.stall_o) stall_cycles++;
            tick();
            bus.wb_valid_i   = 1'b0;
            bus.mem_rvalid_i = 1'b0;
        end
        if (rv_at >= 0) begin
            if (rd != 5'd0) model[rd] = data;
            exp_retired++;
        end
    endtask

    initial begin
        clear_inputs();
        do_reset();

        check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        check("rst_err", {31'd0, bus.load_err_o}, 32'd0);
        check("rst_retired", bus.retired_cnt_o, 32'd0);
        push_reg("rst_x5", 5'd5);
        drain_reads();

        wb_op(TYPER, 5'd5, WB_SEL_ALU, 32'h1234_5678, '0, '0);
        push_reg("r_x5", 5'd5);
        drain_reads();
        bus.rs1_i = 5'd5;
        bus.valid_src1_i = 1'b0;
        #1;
        check("gated_val1", bus.val1_o, 32'd0);
        check("retired_1", bus.retired_cnt_o, exp_retired);

        wb_op(TYPEI, 5'd0, WB_SEL_ALU, 32'hFFFF_FFFF, '0, '0);
        wb_op(TYPES, 5'd7, WB_SEL_ALU, 32'h7777_7777, '0, '0);
        wb_op(TYPEB, 5'd7, WB_SEL_ALU, 32'h8888_8888, '0, '0);
        push_reg("x0_zero", 5'd0);
        push_reg("sb_x7", 5'd7);
        drain_reads();
        check("retired_sb", bus.retired_cnt_o, exp_retired);

        load_seq(5'd3, 32'hDEAD_BEEF, 3, 4);
        check("load_stall_cycles", stall_cycles, 32'd4);
        check("load_stall_drop", {31'd0, bus.stall_o}, 32'd0);
        check("load_retired", bus.retired_cnt_o, exp_retired);
        push_reg("load_x3", 5'd3);
        drain_reads();

        load_seq(5'd4, 32'hCAFE_F00D, 4, 5);
        check("edge_stall_cycles", stall_cycles, 32'd5);
        check("edge_no_err", {31'd0, bus.load_err_o}, 32'd0);
        check("edge_retired", bus.retired_cnt_o, exp_retired);
        push_reg("edge_x4", 5'd4);
        drain_reads();

        load_seq(5'd3, 32'h1111_2222, -1, 5);
        check("to_stall_cycles", stall_cycles, 32'd5);
        check("to_err", {31'd0, bus.load_err_o}, 32'd1);
        check("to_stall_drop", {31'd0, bus.stall_o}, 32'd0);
        check("to_retired", bus.retired_cnt_o, exp_retired);
        push_reg("to_x3", 5'd3);
        drain_reads();

        wb_op(TYPER, 5'd1, WB_SEL_ALU, 32'h0000_0011, '0, '0);
        wb_op(TYPEJ, 5'd1, WB_SEL_PC4, 32'h5555_5555, 32'hFFFF_FFFC, '0);
        wb_op(TYPEU, 5'd2, WB_SEL_IMM, 32'h5555_5555, '0, 32'hABCD_E000);
        push_reg("jal_wrap_x1", 5'd1);
        push_reg("lui_x2", 5'd2);
        drain_reads();

        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h9999_9999;
        wb_op(TYPER, 5'd8, WB_SEL_ALU, 32'h0000_0088, '0, '0);
        bus.mem_rvalid_i = 1'b0;
        push_reg("spurious_x8", 5'd8);
        drain_reads();
        check("err_sticky", {31'd0, bus.load_err_o}, 32'd1);
        check("retired_pre_rst", bus.retired_cnt_o, exp_retired);

        wb_op(TYPER, 5'd9, WB_SEL_ALU, 32'h0000_0033, '0, '0);
        bus.wb_valid_i   = 1'b1;
        bus.instr_type_i = TYPER;
        bus.rd_i         = 5'd9;
        bus.wb_sel_i     = WB_SEL_ALU;
        bus.alu_result_i = 32'h0000_0055;
        bus.rs2_i        = 5'd9;
        bus.valid_src2_i = 1'b1;
        #1;
`ifdef WB_BYPASS_EN
        check("bypass_same_cycle", bus.val2_o, 32'h0000_0055);
`else
        check("no_bypass_old", bus.val2_o, 32'h0000_0033);
`endif
        tick();
        bus.wb_valid_i = 1'b0;
        model[9] = 32'h0000_0055;
        exp_retired++;
        check("bypass_after", bus.val2_o, model[9]);
        bus.valid_src2_i = 1'b0;

        bus.wb_valid_i   = 1'b1;
        bus.instr_type_i = TYPEI;
        bus.rd_i         = 5'd6;
        bus.wb_sel_i     = WB_SEL_MEM;
        bus.mem_rvalid_i = 1'b0;
        tick();
        bus.wb_valid_i = 1'b0;
        tick();
        check("midwait_stall", {31'd0, bus.stall_o}, 32'd1);
        rst_n = 1'b0;
        #2;
        check("rst_midwait_stall", {31'd0, bus.stall_o}, 32'd0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_retired = 0;
        rst_n = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h6666_6666;
        tick();
        bus.mem_rvalid_i = 1'b0;
        check("rst_drop_stall", {31'd0, bus.stall_o}, 32'd0);
        check("rst_drop_retired", bus.retired_cnt_o, 32'd0);
        check("rst_drop_err", {31'd0, bus.load_err_o}, 32'd0);
        push_reg("rst_drop_x6", 5'd6);
        push_reg("rst_clr_x9", 5'd9);
        drain_reads();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
